// File: rtl/branch_comp_seq.sv
// branch_comp_seq: multi-cycle RV32I branch comparator.
// Operands are compared CHUNK_WIDTH bits per cycle, most significant chunk
// first, over a valid/ready request handshake and a valid/ready result
// handshake. Decodes BEQ/BNE/BLT/BGE/BLTU/BGEU into equal, less-than and taken.
// Optional macro BRCOMP_EARLY_EXIT_EN: stop at the first differing chunk.
// Without it every request walks all chunks (constant latency); results are
// identical in both builds.
module branch_comp_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic [2:0]            i_funct3,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_BrEq,
  output logic                  o_BrLT,
  output logic                  o_BrTaken
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMP  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                               state_r;
  logic [NCHUNK-1:0][CHUNK_WIDTH-1:0]   op1_r;
  logic [NCHUNK-1:0][CHUNK_WIDTH-1:0]   op2_r;
  logic [2:0]                           funct3_r;
  logic [IDX_W-1:0]                     idx_r;
  logic                                 valid_r;
  logic                                 eq_r;
  logic                                 lt_r;
  logic                                 taken_r;

  logic [DATA_WIDTH-1:0]                sign_flip_s;
  logic [CHUNK_WIDTH-1:0]               chunk1_s;
  logic [CHUNK_WIDTH-1:0]               chunk2_s;
  logic                                 chunk_diff_s;
  logic                                 chunk_lt_s;
  logic                                 cmp_last_s;
  logic                                 res_found_s;
  logic                                 res_lt_s;

  // Branch decision from funct3 and the compare result; reserved codes never take.
  function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      3'b000:  t = eq;
      3'b001:  t = ~eq;
      3'b100:  t = lt;
      3'b101:  t = ~lt;
      3'b110:  t = lt;
      3'b111:  t = ~lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign o_ready   = (state_r == IDLE) && i_rst_n;
  assign o_valid   = valid_r;
  assign o_BrEq    = eq_r;
  assign o_BrLT    = lt_r;
  assign o_BrTaken = taken_r;

  // Signed compares flip both operand MSBs once at capture, so every chunk
  // (including the top one) can then be compared unsigned.
  always_comb begin
    sign_flip_s = '0;
    sign_flip_s[DATA_WIDTH-1] = ~i_funct3[1];
  end

  // Current chunk compare.
  always_comb begin
    chunk1_s     = op1_r[idx_r];
    chunk2_s     = op2_r[idx_r];
    chunk_diff_s = (chunk1_s != chunk2_s);
    chunk_lt_s   = (chunk1_s < chunk2_s);
  end

`ifdef BRCOMP_EARLY_EXIT_EN
  // Early exit: the first differing chunk finishes the compare.
  always_comb begin
    res_found_s = chunk_diff_s;
    res_lt_s    = chunk_lt_s;
    cmp_last_s  = chunk_diff_s || (idx_r == '0);
  end
`else
  logic found_r;
  logic found_lt_r;

  // Constant latency: remember the first differing chunk, keep walking to chunk 0.
  always_comb begin
    res_found_s = found_r | chunk_diff_s;
    if (found_r) begin
      res_lt_s = found_lt_r;
    end else begin
      res_lt_s = chunk_lt_s;
    end
    cmp_last_s = (idx_r == '0);
  end

  // Latch of the first differing chunk's verdict; cleared while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      found_r    <= 1'b0;
      found_lt_r <= 1'b0;
    end else if (state_r == CMP) begin
      found_r    <= res_found_s;
      found_lt_r <= res_lt_s;
    end else begin
      found_r    <= 1'b0;
      found_lt_r <= 1'b0;
    end
  end
`endif

  // Request capture, chunk walk and result handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= IDLE;
      op1_r    <= '0;
      op2_r    <= '0;
      funct3_r <= 3'b000;
      idx_r    <= '0;
      valid_r  <= 1'b0;
      eq_r     <= 1'b0;
      lt_r     <= 1'b0;
      taken_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            op1_r    <= i_data1 ^ sign_flip_s;
            op2_r    <= i_data2 ^ sign_flip_s;
            funct3_r <= i_funct3;
            idx_r    <= IDX_TOP;
            state_r  <= CMP;
          end
        end
        CMP: begin
          if (cmp_last_s) begin
            eq_r    <= ~res_found_s;
            lt_r    <= res_lt_s;
            taken_r <= taken_of(funct3_r, ~res_found_s, res_lt_s);
            valid_r <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Self-checking bench for branch_comp_seq: directed table, hand-written
// backpressure / reset / reserved-funct3 sequences, and randomized requests
// against a behavioural reference model.
module tb_branch_comp_seq;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, o_valid, i_ready;
  logic [31:0] d1, d2;
  logic [2:0]  f3;
  logic        eq, lt, tk;

  logic        v2, rdy2, ov2, ir2, eq2, lt2, tk2;
  logic [15:0] e1, e2;
  logic [2:0]  g3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_comp_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data1(d1), .i_data2(d2), .i_funct3(f3), .o_valid(o_valid),
    .i_ready(i_ready), .o_BrEq(eq), .o_BrLT(lt), .o_BrTaken(tk)
  );

  branch_comp_seq #(.DATA_WIDTH(16), .CHUNK_WIDTH(4)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(rdy2),
    .i_data1(e1), .i_data2(e2), .i_funct3(g3), .o_valid(ov2),
    .i_ready(ir2), .o_BrEq(eq2), .o_BrLT(lt2), .o_BrTaken(tk2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference result {eq, lt, taken} straight from the branch semantics.
  function automatic logic [2:0] m_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    logic e, l, t;
    e = (a == b);
    if (f[1]) l = (a < b);
    else      l = ($signed(a) < $signed(b));
    case (f)
      3'd0:          t = e;
      3'd1:          t = !e;
      3'd4, 3'd6:    t = l;
      3'd5, 3'd7:    t = !l;
      default:       t = 1'b0;
    endcase
    return {e, l, t};
  endfunction

  // Reference latency: edges from accept to o_valid high.
  function automatic int m_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef BRCOMP_EARLY_EXIT_EN
    logic [31:0] x;
    x = a ^ b;
    for (int p = 31; p >= 0; p--) begin
      if (x[p]) return NCH - p / CW;
    end
    return NCH;
`else
    return NCH;
`endif
  endfunction

  // One request on the 32-bit DUT; called and returning at #1 after a posedge.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input logic [2:0] exp, input int exp_lat, input int hold,
                        input bit pre_ready, input string name);
    int lat;
    check({name, ".ready_idle"}, o_ready, 1);
    d1 = a; d2 = b; f3 = f; i_valid = 1'b1; i_ready = pre_ready;
    @(posedge clk); #1;
    i_valid = 1'b0; d1 = $urandom; d2 = $urandom; f3 = 3'($urandom);
    check({name, ".ready_busy"}, o_ready, 0);
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".valid_seen"}, o_valid, 1);
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    check({name, ".eq_lt_taken"}, {eq, lt, tk}, exp);
    if (!pre_ready) begin
      for (int h = 0; h < hold; h++) begin
        d1 = $urandom; d2 = $urandom; i_valid = 1'b1;
        @(posedge clk); #1;
        check({name, ".hold_valid"}, o_valid, 1);
        check({name, ".hold_ready"}, o_ready, 0);
        check({name, ".hold_out"}, {eq, lt, tk}, exp);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
    end
    @(posedge clk); #1;
    i_ready = 1'b0;
    check({name, ".valid_drop"}, o_valid, 0);
    check({name, ".ready_back"}, o_ready, 1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [2:0]  exp;   // {eq, lt, taken}
    int          k_ee;  // chunks examined with early exit
    bit          pre;   // i_ready already high when o_valid rises
  } vec_t;

  vec_t vt[8];

  initial begin
    int lat;
    logic [31:0] a, b, r;
    rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b0; d1 = '0; d2 = '0; f3 = '0;
    v2 = 1'b0; ir2 = 1'b0; e1 = '0; e2 = '0; g3 = '0;

    vt[0] = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 3'b011, 1, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 3'b000, 1, 1'b0};
    vt[2] = '{32'h12000000, 32'h13000000, 3'b110, 3'b011, 1, 1'b0};
    vt[3] = '{32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 3'b101, 4, 1'b0};
    vt[4] = '{32'hDEADBEEF, 32'hDEADBEEF, 3'b001, 3'b100, 4, 1'b1};
    vt[5] = '{32'h80000000, 32'h7FFFFFFF, 3'b101, 3'b010, 1, 1'b0};
    vt[6] = '{32'h00000001, 32'h00000002, 3'b011, 3'b010, 4, 1'b0};
    vt[7] = '{32'h7FFFFFFF, 32'h80000000, 3'b110, 3'b011, 1, 1'b1};

    // Reset state
    #2 rst_n = 1'b0;
    #5;
    check("reset.ready", o_ready, 0);
    check("reset.valid", o_valid, 0);
    check("reset.outs", {eq, lt, tk}, 3'b000);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset.ready_after", o_ready, 1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
`ifdef BRCOMP_EARLY_EXIT_EN
      lat = vt[i].k_ee;
`else
      lat = NCH;
`endif
      do_req(vt[i].a, vt[i].b, vt[i].f, vt[i].exp, lat, 0, vt[i].pre, $sformatf("vec%0d", i));
    end

    // Backpressure: 3 cycles of i_ready=0 with i_valid pulsed by new operands
    do_req(32'h00000005, 32'h00000003, 3'b111, 3'b001, NCH, 3, 1'b0, "bp");
    repeat (3) begin
      @(posedge clk); #1;
      check("bp.no_ghost", o_valid, 0);
    end

    // Reset in the middle of an equality walk
    check("rst_mid.ready", o_ready, 1);
    d1 = 32'hDEADBEEF; d2 = 32'hDEADBEEF; f3 = 3'b000; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.valid", o_valid, 0);
    check("rst_mid.outs", {eq, lt, tk}, 3'b000);
    check("rst_mid.ready", o_ready, 0);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("rst_mid.no_result", o_valid, 0);
    end
    do_req(32'h80000000, 32'h7FFFFFFF, 3'b101, 3'b010, m_lat(32'h80000000, 32'h7FFFFFFF), 0, 1'b0, "rst_bge");

    // Reserved funct3 on the 16-bit / 4-bit-chunk instance
    check("r16.ready", rdy2, 1);
    e1 = 16'h0001; e2 = 16'h0002; g3 = 3'b011; v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("r16.latency", 32'(lat), 32'd4);
    check("r16.eq_lt_taken", {eq2, lt2, tk2}, 3'b010);
    ir2 = 1'b1;
    @(posedge clk); #1;
    ir2 = 1'b0;
    check("r16.valid_drop", ov2, 0);

    // Randomized requests against the reference model
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, 31));
        2:       b = {a[31:16], r[15:0]};
        default: b = r;
      endcase
      r = $urandom_range(0, 7);
      do_req(a, b, r[2:0], m_res(a, b, r[2:0]), m_lat(a, b), $urandom_range(0, 2),
             ($urandom_range(0, 3) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
